// File: rtl/pinwheel_serial_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : pinwheel_serial_loader_pkg
// Brief    : TileLink channel types, opcodes and loader FSM states.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pinwheel_serial_loader_pkg;

  localparam logic [2:0] TL_PUT_FULL   = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK = 3'd0;
  localparam logic [2:0] TL_SIZE_WORD  = 3'd2;
  localparam logic [3:0] TL_MASK_WORD  = 4'hF;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_error;
    logic [31:0] d_data;
  } tilelink_d;

  typedef enum logic [2:0] {
    ADDR = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state;

endpackage

`default_nettype wire

// File: rtl/pinwheel_serial_loader_serial_word_assembler.sv
//------------------------------------------------------------------------------
// Module   : serial_word_assembler
// Brief    : Packs four little-endian serial bytes into a 32-bit word.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_word_assembler
  import pinwheel_serial_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_in,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_lanes;

  // The top lane is never stored: the 4th byte is forwarded straight into the word.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      r_byte_idx <= 2'd0;
      r_lanes    <= 24'd0;
    end else if (byte_valid) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      case (r_byte_idx)
        2'd0:    r_lanes[7:0]   <= byte_data;
        2'd1:    r_lanes[15:8]  <= byte_data;
        2'd2:    r_lanes[23:16] <= byte_data;
        default: r_lanes        <= r_lanes;
      endcase
    end
  end

  assign word_valid = byte_valid && (r_byte_idx == 2'd3);
  assign word       = {byte_data, r_lanes};

endmodule

`default_nettype wire

// File: rtl/pinwheel_serial_loader.sv
//------------------------------------------------------------------------------
// Module   : pinwheel_serial_loader
// Brief    : Serial boot loader issuing TileLink PutFullData writes; holds the
//            core in reset until the image is written and acknowledged.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pinwheel_serial_loader
  import pinwheel_serial_loader_pkg::*;
#(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic       serial_valid,
  input  logic [7:0] serial_data,
  output tilelink_a  bus_tla,
  input  tilelink_d  bus_tld,
  output logic       core_hold,
  output logic       busy,
  output logic       done,
  output logic       error
);

  loader_state r_state;
  loader_state w_state_next;

  logic [31:0] r_base;
  logic [31:0] r_count;
  logic [31:0] r_word_idx;
  logic        r_pending;
  logic [7:0]  r_tmo;

  logic        w_asm_byte_valid;
  logic        w_asm_valid;
  logic [31:0] w_asm_word;
  logic        w_ack_seen;
  logic        w_ack_ok;
  logic        w_ack_bad;
  logic        w_timeout;
  logic [31:0] w_idx_next;
  logic        w_last_ack;
  logic        w_issue;
  logic        w_busy_next;
  logic        w_done_next;
  logic        w_error_next;
  logic        w_hold_next;
  logic        w_unused_tld;

  assign w_unused_tld = &{1'b0, bus_tld.d_param, bus_tld.d_size,
                          bus_tld.d_source, bus_tld.d_data};

  // Bytes are only consumed while parsing; DONE and ERR drop them.
  assign w_asm_byte_valid = serial_valid && busy;

  serial_word_assembler u_assembler (
    .clock      (clock),
    .reset_in   (reset_in),
    .byte_valid (w_asm_byte_valid),
    .byte_data  (serial_data),
    .word_valid (w_asm_valid),
    .word       (w_asm_word)
  );

  assign w_ack_seen = (r_state == DATA) && r_pending && bus_tld.d_valid &&
                      (bus_tld.d_opcode == TL_ACCESS_ACK);
  assign w_ack_ok   = w_ack_seen && !bus_tld.d_error;
  assign w_ack_bad  = w_ack_seen && bus_tld.d_error;
  assign w_timeout  = (r_state == DATA) && r_pending && !w_ack_seen &&
                      (r_tmo == ACK_TIMEOUT);
  assign w_idx_next = r_word_idx + {31'd0, w_ack_ok};
  assign w_last_ack = w_ack_ok && (w_idx_next == r_count);

  // An ack landing in the same cycle a word completes retires the old write first.
  assign w_issue = (r_state == DATA) && (w_state_next == DATA) && w_asm_valid;

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      r_state   <= ADDR;
      core_hold <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      core_hold <= w_hold_next;
      busy      <= w_busy_next;
      done      <= w_done_next;
      error     <= w_error_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ADDR: if (w_asm_valid) w_state_next = LEN;
      LEN:  if (w_asm_valid) w_state_next = (w_asm_word == 32'd0) ? DONE : DATA;
      DATA: begin
        if (w_ack_bad || w_timeout)
          w_state_next = ERR;
        else if (w_last_ack)
          w_state_next = DONE;
        else if (w_asm_valid && r_pending && !w_ack_ok)
          w_state_next = ERR;
      end
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    w_busy_next  = (w_state_next == ADDR) || (w_state_next == LEN) ||
                   (w_state_next == DATA);
    w_done_next  = (w_state_next == DONE);
    w_error_next = (w_state_next == ERR);
    w_hold_next  = (w_state_next != DONE);
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      r_base     <= 32'd0;
      r_count    <= 32'd0;
      r_word_idx <= 32'd0;
      r_pending  <= 1'b0;
      r_tmo      <= 8'd0;
      bus_tla    <= '0;
    end else begin
      bus_tla.a_valid <= w_issue;
      if ((r_state == ADDR) && w_asm_valid) r_base  <= w_asm_word;
      if ((r_state == LEN) && w_asm_valid)  r_count <= w_asm_word;
      if (w_ack_ok) r_word_idx <= w_idx_next;

      if (w_issue) begin
        bus_tla.a_opcode  <= TL_PUT_FULL;
        bus_tla.a_param   <= 3'd0;
        bus_tla.a_size    <= TL_SIZE_WORD;
        bus_tla.a_source  <= 4'd0;
        bus_tla.a_mask    <= TL_MASK_WORD;
        bus_tla.a_data    <= w_asm_word;
        bus_tla.a_address <= r_base + (w_idx_next << 2);
        r_pending         <= 1'b1;
        r_tmo             <= 8'd0;
      end else if (w_ack_seen) begin
        r_pending <= 1'b0;
        r_tmo     <= 8'd0;
      end else if (r_pending && !bus_tla.a_valid && (r_tmo != ACK_TIMEOUT)) begin
        r_tmo <= r_tmo + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pinwheel_serial_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_pinwheel_serial_loader
// Brief    : Directed bench for the serial boot loader with a 1-cycle RAM model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pinwheel_serial_loader;
  import pinwheel_serial_loader_pkg::*;

  logic       clock = 1'b0;
  logic       reset_in;
  logic       serial_valid;
  logic [7:0] serial_data;
  tilelink_a  bus_tla;
  tilelink_d  bus_tld = '0;
  logic       core_hold;
  logic       busy;
  logic       done;
  logic       error;

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;
  int ack_mode = 0;  // 0: never ack, 1: ack, 2: ack with d_error
  int snap;

  always #5 clock = ~clock;

  pinwheel_serial_loader dut (
    .clock        (clock),
    .reset_in     (reset_in),
    .serial_valid (serial_valid),
    .serial_data  (serial_data),
    .bus_tla      (bus_tla),
    .bus_tld      (bus_tld),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // RAM model: answers a write on the edge following its a_valid cycle.
  always @(negedge clock) begin
    bus_tld = '0;
    if (bus_tla.a_valid) begin
      wr_count = wr_count + 1;
      if (ack_mode != 0) begin
        bus_tld.d_valid  = 1'b1;
        bus_tld.d_opcode = TL_ACCESS_ACK;
        bus_tld.d_error  = (ack_mode == 2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    serial_valid = 1'b1;
    serial_data  = b;
    step();
    serial_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_in     = 1'b1;
    serial_valid = 1'b0;
    step();
    step();
    reset_in = 1'b0;
    step();
  endtask

  initial begin
    reset_in     = 1'b1;
    serial_valid = 1'b0;
    serial_data  = 8'h00;
    ack_mode     = 1;
    step();
    step();
    chk("rst_core_hold", core_hold, 1);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_tla", bus_tla, 0);
    reset_in = 1'b0;
    step();

    // Two-word image at 0x80000000 with acking RAM
    snap = wr_count;
    send_word(32'h8000_0000);
    send_word(32'd2);
    chk("hdr_busy", busy, 1);
    chk("hdr_no_write", bus_tla.a_valid, 0);
    send_word(32'h1234_5678);
    chk("w0_valid", bus_tla.a_valid, 1);
    chk("w0_addr", bus_tla.a_address, 32'h8000_0000);
    chk("w0_data", bus_tla.a_data, 32'h1234_5678);
    chk("w0_size", bus_tla.a_size, 2);
    chk("w0_mask", bus_tla.a_mask, 4'hF);
    chk("w0_opcode", bus_tla.a_opcode, 0);
    send(8'hEF);
    chk("w0_one_cycle", bus_tla.a_valid, 0);
    send(8'hBE);
    send(8'hAD);
    send(8'hDE);
    chk("w1_valid", bus_tla.a_valid, 1);
    chk("w1_addr", bus_tla.a_address, 32'h8000_0004);
    chk("w1_data", bus_tla.a_data, 32'hDEAD_BEEF);
    chk("w1_done_early", done, 0);
    chk("w1_hold_early", core_hold, 1);
    step();
    chk("img_done", done, 1);
    chk("img_core_hold", core_hold, 0);
    chk("img_busy", busy, 0);
    chk("img_error", error, 0);
    chk("img_writes", wr_count - snap, 2);
    snap = wr_count;
    send_word(32'hAABB_CCDD);
    step();
    chk("done_ignores_bytes", wr_count - snap, 0);
    chk("done_sticky", done, 1);

    // Zero-length image
    do_reset();
    snap = wr_count;
    send_word(32'h0000_0040);
    send_word(32'd0);
    chk("n0_done", done, 1);
    chk("n0_core_hold", core_hold, 0);
    chk("n0_busy", busy, 0);
    step();
    chk("n0_no_write", wr_count - snap, 0);

    // Address wraps modulo 2^32
    do_reset();
    send_word(32'hFFFF_FFFC);
    send_word(32'd2);
    send_word(32'h0000_0001);
    chk("wrap_addr0", bus_tla.a_address, 32'hFFFF_FFFC);
    send_word(32'h0000_0002);
    chk("wrap_addr1", bus_tla.a_address, 32'h0000_0000);
    step();
    chk("wrap_done", done, 1);

    // Ack timeout
    do_reset();
    ack_mode = 0;
    send_word(32'h0000_1000);
    send_word(32'd2);
    send_word(32'hCAFE_F00D);
    chk("tmo_write", bus_tla.a_valid, 1);
    repeat (256) step();
    chk("tmo_not_yet", error, 0);
    step();
    chk("tmo_error", error, 1);
    chk("tmo_core_hold", core_hold, 1);
    chk("tmo_busy", busy, 0);
    snap = wr_count;
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    step();
    chk("tmo_no_more_writes", wr_count - snap, 0);
    chk("tmo_error_sticky", error, 1);

    // Overrun while ack withheld
    do_reset();
    send_word(32'h0000_0000);
    send_word(32'd4);
    send_word(32'h1111_1111);
    send(8'h22);
    send(8'h22);
    send(8'h22);
    chk("ovr_not_yet", error, 0);
    send(8'h22);
    chk("ovr_error", error, 1);
    chk("ovr_no_write", bus_tla.a_valid, 0);
    chk("ovr_core_hold", core_hold, 1);

    // Ack carrying d_error
    do_reset();
    ack_mode = 2;
    send_word(32'h0000_2000);
    send_word(32'd1);
    send_word(32'h55AA_55AA);
    chk("derr_write", bus_tla.a_valid, 1);
    step();
    chk("derr_error", error, 1);
    chk("derr_done", done, 0);
    chk("derr_core_hold", core_hold, 1);

    // Asynchronous reset after 5 data bytes, then a fresh load
    do_reset();
    ack_mode = 1;
    send_word(32'h8000_0000);
    send_word(32'd2);
    send_word(32'h1234_5678);
    send(8'h9A);
    #1;
    reset_in = 1'b1;
    #1;
    chk("arst_tla", bus_tla, 0);
    chk("arst_core_hold", core_hold, 1);
    chk("arst_busy", busy, 1);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    step();
    reset_in = 1'b0;
    step();
    send_word(32'h0000_0100);
    send_word(32'd1);
    send_word(32'h4433_2211);
    chk("fresh_addr", bus_tla.a_address, 32'h0000_0100);
    chk("fresh_data", bus_tla.a_data, 32'h4433_2211);
    step();
    chk("fresh_done", done, 1);
    chk("fresh_core_hold", core_hold, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pinwheel_serial_loader.md
# pinwheel_serial_loader

Boot-time loader that sits directly upstream of the pinwheel memory bus. It receives a byte stream on the serial port, parses a fixed header, and issues TileLink PutFullData writes into code or data RAM. It holds the core in reset until the image is fully written and acknowledged, so firmware can be loaded without hex files.

## Interface
Parameters:
- ack_timeout, 255: max cycles to wait for AccessAck before flagging error (8-bit counter).

Ports:
- clock  in  1  global clock.
- reset_in  in  1  asynchronous, active-high reset.
- serial_valid  in  1  one-cycle strobe, byte present on serial_data.
- serial_data  in  8  received byte.
- bus_tla  out  tilelink_a  write request to the RAM address decode.
- bus_tld  in  tilelink_d  response from the RAM or debug register, same mux the core uses.
- core_hold  out  1  drives the core's reset; high until load completes.
- busy  out  1  high while in ADDR, LEN or DATA.
- done  out  1  sticky; image written and all writes acked.
- error  out  1  sticky; overrun or ack timeout.

## Operation
- Stream format, little-endian throughout: 4 bytes base address, 4 bytes word count N, then N×4 data bytes.
- States:
  - ADDR: collect 4 bytes into base, then go to LEN.
  - LEN: collect 4 bytes into count. If N==0, go to DONE; otherwise go to DATA.
  - DATA: assemble words, issue writes, track acks.
  - DONE: terminal.
  - ERR: terminal.
- Byte assembly: byte_idx (2 bits) selects the lane, byte_idx 0 → bits [7:0]. The 4th byte completes the word.
- Write issue, on word completion:
  - a_opcode=0 (PutFullData), a_param=0, a_size=2, a_source=0.
  - a_mask=4'hF, a_data=word, a_address=base + (word_idx<<2). The address is 32-bit and wraps modulo 2^32.
- One write is outstanding at a time. The next word may be assembled while an ack is pending, into a separate assembly register.
- Overrun: a word completes while the previous write is still unacked → ERR.
- Ack: bus_tld.d_valid==1 with d_opcode==0 (AccessAck) retires the write and increments word_idx.
  - d_error==1 → ERR.
  - d_valid in any state other than DATA-with-pending-write is ignored.
- DONE is entered on the ack of word N-1. core_hold falls in the same cycle done rises.
- ERR: core_hold stays high, and further bytes are ignored. Only reset_in leaves DONE or ERR.
- Bytes arriving in DONE are ignored.

## Timing
- Reset values:
  - state=ADDR, all counters 0.
  - bus_tla all fields 0 (a_valid=0).
  - core_hold=1, busy=1, done=0, error=0.
- reset_in mid-operation: immediate return to reset values. The in-flight write is abandoned (a_valid drops asynchronously).
- a_valid is registered: high exactly one cycle, in the cycle after the strobe carrying the word's 4th byte. No a_ready backpressure; pinwheel slaves always accept.
- Ack timeout:
  - Counter starts the cycle after a_valid and is cleared on ack.
  - Reaching ack_timeout with no ack → ERR on the next edge.
- Best-case throughput: 4 serial strobes per word. Back-to-back strobes are legal.
- done/error/core_hold/busy are registered. There is no combinational path from bus_tld to bus_tla.

## Structure
- Add to the shared tilelink package:
  - TL_PUT_FULL=3'd0 and TL_ACCESS_ACK=3'd0 constants.
  - a loader_state enum (ADDR, LEN, DATA, DONE, ERR).
- The module reuses the existing tilelink_a / tilelink_d typedefs.
- Sub-module serial_word_assembler: byte_idx plus the 32-bit shift register, with a word_valid pulse output. It is reused for the header fields and for data.
- Top-level integration:
  - The loader's bus_tla is muxed with the core's bus_tla while core_hold=1.
  - core_tock_reset_in = reset_in | core_hold.

## Test plan
- Header 00 00 00 80 / 02 00 00 00, data 78 56 34 12 EF BE AD DE, RAM acks after 1 cycle:
  - writes 0x12345678@0x80000000 then 0xDEADBEEF@0x80000004;
  - done=1 and core_hold=0 in the cycle the second ack lands.
- N=0 header → DONE right after the 8th byte, with no a_valid ever asserted.
- Withhold the ack for 256 cycles after the first write → error=1, core_hold stays 1, and later bytes produce no a_valid.
- Withhold the ack while 4 more data bytes arrive → error=1 on the 4th byte.
- Ack with d_error=1 → error=1.
- Assert reset_in after 5 data bytes → all outputs return to reset values. A full fresh stream then loads correctly from the ADDR state.
